uart_rx: RTL and testbench

- Serial receiver that consumes the `serial` line driven by `uart_tx`, or by an external console pin.
- Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) at CLK_PER_BIT clocks per bit.
- Presents each byte as a one-cycle `data_valid` pulse to the console mux.
- Bit timing is compatible with `uart_tx` at the same CLK_PER_BIT, so the pair can be looped back.

---
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop input synchroniser, mid-bit sampling FSM,
// single-cycle data_valid / frame_err pulses.
module uart_rx #(
  parameter int unsigned CLK_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_e;

  state_e          state_q, state_d;
  logic            sync_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            dv_q, dv_d;
  logic            fe_q, fe_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; synchroniser resets to the idle line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync_q  <= serial;
      rx_s_q  <= sync_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!rx_s_q) state_d = START;
      START: if (cnt_q == CNT_MID) state_d = rx_s_q ? IDLE : DATA;
      DATA:  if (cnt_q == CNT_LAST && idx_q == 3'd7) state_d = STOP;
      STOP:  if (cnt_q == CNT_LAST) state_d = rx_s_q ? IDLE : BRK;
      BRK:   if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      IDLE: cnt_d = '0;
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          idx_d = '0;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          if (rx_s_q) begin
            data_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end
      end
      BRK: cnt_d = '0;
      default: cnt_d = '0;
    endcase
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx; frames are generated bit by bit
// and compared against an expected-event list built from the frame contents.
module tb_uart_rx;

  localparam int CPB = 100;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int cyc = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int busy_fall_cyc = -1;
  logic busy_prev = 1'b0;
  logic [7:0] dv_data[$];
  int         dv_cyc[$];

  uart_rx #(.CLK_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial     (serial),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Event recorder, sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rst_n) begin
      if (data_valid) begin
        dv_data.push_back(data);
        dv_cyc.push_back(cyc);
      end
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (data_valid && frame_err) both_cnt = both_cnt + 1;
      if (busy_prev && !busy) busy_fall_cyc = cyc;
    end
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    serial = v;
    repeat (n) @(negedge clk);
  endtask

  // Returns the index of the first clock edge that sees the start bit
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len,
                            output int t_start);
    t_start = cyc + 1;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_v, stop_len);
  endtask

  initial begin
    int t0, t1, n0, fe0, lat;
    logic [7:0] exp_q[$];
    int exp_fe;
    logic [7:0] last_good;
    logic [7:0] fr;

    @(negedge clk);
    #1;
    chk("reset_data", 32'(data), 32'h00);
    chk("reset_dv", 32'(data_valid), 32'd0);
    chk("reset_fe", 32'(frame_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    hold(1'b1, 20 * CPB);
    chk("idle_dv_count", 32'(dv_data.size()), 32'd0);
    chk("idle_fe_count", 32'(fe_cnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_data", 32'(data), 32'h00);

    // Single frame 0x63 with latency and busy-fall timing
    send_frame(8'h63, 1'b1, CPB, t0);
    hold(1'b1, CPB);
    chk("f63_count", 32'(dv_data.size()), 32'd1);
    if (dv_data.size() >= 1) begin
      chk("f63_data", 32'(dv_data[0]), 32'h63);
      lat = dv_cyc[0] - t0;
      chk("f63_latency_ok", 32'((lat >= LAT - 1) && (lat <= LAT + 1)), 32'd1);
      chk("f63_busy_fall", 32'(busy_fall_cyc), 32'(dv_cyc[0]));
    end
    chk("f63_data_hold", 32'(data), 32'h63);

    // Back-to-back 0x63, 0xA5
    dv_data.delete();
    dv_cyc.delete();
    send_frame(8'h63, 1'b1, CPB, t0);
    send_frame(8'hA5, 1'b1, CPB, t1);
    hold(1'b1, CPB);
    chk("b2b_count", 32'(dv_data.size()), 32'd2);
    if (dv_data.size() >= 2) begin
      chk("b2b_first", 32'(dv_data[0]), 32'h63);
      chk("b2b_second", 32'(dv_data[1]), 32'hA5);
    end
    chk("b2b_no_fe", 32'(fe_cnt), 32'd0);

    // 30-cycle glitch, then frame 0x3C
    dv_data.delete();
    hold(1'b0, 30);
    hold(1'b1, 30);
    chk("glitch_busy", 32'(busy), 32'd0);
    hold(1'b1, 2 * CPB);
    chk("glitch_no_dv", 32'(dv_data.size()), 32'd0);
    chk("glitch_no_fe", 32'(fe_cnt), 32'd0);
    send_frame(8'h3C, 1'b1, CPB, t0);
    hold(1'b1, CPB);
    chk("f3c_count", 32'(dv_data.size()), 32'd1);
    chk("f3c_data", 32'(data), 32'h3C);

    // 0xFF with low stop bit, then break held low
    dv_data.delete();
    send_frame(8'hFF, 1'b0, CPB, t0);
    hold(1'b0, 5 * CPB);
    chk("brk_busy_low", 32'(busy), 32'd1);
    chk("brk_fe_count", 32'(fe_cnt), 32'd1);
    chk("brk_no_dv", 32'(dv_data.size()), 32'd0);
    hold(1'b1, 5);
    chk("brk_busy_release", 32'(busy), 32'd0);
    chk("brk_data_kept", 32'(data), 32'h3C);
    hold(1'b1, CPB);
    chk("brk_fe_final", 32'(fe_cnt), 32'd1);

    // Reset during bit 4 of 0x81, then 0x42
    fr = 8'h81;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(fr[i], CPB);
    hold(fr[4], CPB / 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(data), 32'h00);
    chk("mid_rst_dv", 32'(data_valid), 32'd0);
    chk("mid_rst_fe", 32'(frame_err), 32'd0);
    @(negedge clk);
    hold(1'b1, 5);
    rst_n = 1'b1;
    hold(1'b1, 3 * CPB);
    chk("mid_rst_no_dv", 32'(dv_data.size()), 32'd0);
    send_frame(8'h42, 1'b1, CPB, t0);
    hold(1'b1, CPB);
    chk("f42_count", 32'(dv_data.size()), 32'd1);
    chk("f42_data", 32'(data), 32'h42);

    // Randomized frames: short stops, gaps, occasional framing errors
    dv_data.delete();
    fe0 = fe_cnt;
    exp_fe = 0;
    last_good = 8'h42;
    for (int k = 0; k < 16; k++) begin
      fr = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        send_frame(fr, 1'b0, CPB, t0);
        hold(1'b0, $urandom_range(0, 3 * CPB));
        hold(1'b1, CPB);
        exp_fe++;
      end else begin
        send_frame(fr, 1'b1, $urandom_range(CPB / 2 + 2, CPB), t0);
        exp_q.push_back(fr);
        last_good = fr;
        hold(1'b1, $urandom_range(0, 2 * CPB));
      end
    end
    hold(1'b1, 2 * CPB);
    n0 = exp_q.size();
    chk("rand_dv_count", 32'(dv_data.size()), 32'(n0));
    for (int k = 0; k < n0; k++) begin
      if (k < dv_data.size()) chk($sformatf("rand_byte%0d", k), 32'(dv_data[k]), 32'(exp_q[k]));
    end
    chk("rand_fe_count", 32'(fe_cnt - fe0), 32'(exp_fe));
    chk("rand_last_data", 32'(data), 32'(last_good));
    chk("rand_idle_busy", 32'(busy), 32'd0);
    chk("never_dv_and_fe", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
